// File: rtl/gaussian_blur_3x3.sv
// -----------------------------------------------------------------------------
// gaussian_blur_3x3
//
// Streaming 3x3 Gaussian smoothing stage that sits in front of the Sobel
// gradient stage. It accepts a raster-order 8-bit grayscale stream, keeps two
// line buffers, and builds a sliding 3x3 window. Each full window is convolved
// with the 1-2-1 / 2-4-2 / 1-2-1 kernel and normalised by 16 with round-half-up.
// Border rows and columns are dropped, so each frame produces (W-2) x (H-2)
// outputs. The latency from the completing input pixel is a fixed 3 cycles.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous, active-high reset
//   in_valid   : in_pixel is presented this cycle (no backpressure)
//   in_pixel   : unsigned grayscale sample, raster order
//   in_sof     : with in_valid, forces this pixel to (row 0, col 0)
//   out_valid  : out_pixel is valid this cycle
//   out_pixel  : filtered sample
//   out_sof    : with out_valid, first output of a frame (centre (1,1))
//   out_eol    : with out_valid, last output of a line (centre col W-2)
// -----------------------------------------------------------------------------
package gaussian_blur_pkg;
    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;
    localparam int PIX_W        = 8;
    localparam int SUM_W        = 12;   // 255 * 16 = 4080 fits in 12 bits
    localparam int NORM_SHIFT   = 4;    // kernel weights sum to 16

    // KERNEL[row][col]; symmetric, so the index order is immaterial.
    localparam logic [2:0][2:0][2:0] KERNEL = {
        3'd1, 3'd2, 3'd1,
        3'd2, 3'd4, 3'd2,
        3'd1, 3'd2, 3'd1
    };
endpackage

module gaussian_blur_3x3 #(
    parameter int IMAGE_WIDTH  = gaussian_blur_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = gaussian_blur_pkg::IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    input  logic       in_sof,
    output logic       out_valid,
    output logic [7:0] out_pixel,
    output logic       out_sof,
    output logic       out_eol
);
    localparam int SUM_W = gaussian_blur_pkg::SUM_W;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);

    typedef logic [gaussian_blur_pkg::PIX_W-1:0] pix_t;

    // ------------------------------------------------------------------
    // Position counters. in_sof overrides the counters so the pixel that
    // carries it is treated as (0,0); the next position follows from there.
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d, col_pos;
    logic [ROW_W-1:0] row_q, row_d, row_pos;
    logic             accept;

    assign accept = in_valid && !rst;   // rst drops a coincident pixel

    // NOTE: always_comb assigns every output a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        col_pos = in_sof ? '0 : col_q;
        row_pos = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (col_pos == COL_W'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_pos == ROW_W'(IMAGE_HEIGHT - 1)) ? '0
                                                              : row_pos + ROW_W'(1);
            end else begin
                col_d = col_pos + COL_W'(1);
                row_d = row_pos;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values that existed before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by col.
    // Writing the new pixel into lb1 and the old lb1 entry into lb2 moves the
    // column down by one row in a single access.
    // ------------------------------------------------------------------
    pix_t lb1_q [IMAGE_WIDTH];
    pix_t lb2_q [IMAGE_WIDTH];
    pix_t lb1_rd, lb2_rd;

    assign lb1_rd = lb1_q[col_pos];
    assign lb2_rd = lb2_q[col_pos];

    // NOTE: the line-buffer memories have no reset; rows 0-1 never produce an
    // output, so stale contents are always overwritten before they are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_pos] <= in_pixel;
            lb2_q[col_pos] <= lb1_rd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window, win_q[col][row]; col 2 / row 2 is the newest.
    // ------------------------------------------------------------------
    pix_t win_q [3][3];
    logic v1_q, sof1_q, eol1_q;
    logic fire;

    assign fire = accept && (row_pos >= ROW_W'(2)) && (col_pos >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q[0]    <= win_q[1];
            win_q[1]    <= win_q[2];
            win_q[2][0] <= lb2_rd;
            win_q[2][1] <= lb1_rd;
            win_q[2][2] <= in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: weighted sum.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] sum_d, sum_q;
    logic             v2_q, sof2_q, eol2_q;

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                sum_d = sum_d + SUM_W'(gaussian_blur_pkg::KERNEL[r][c]) * SUM_W'(win_q[c][r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    // ------------------------------------------------------------------
    // Stage 3: round-half-up normalisation. The maximum (4080 + 8) >> 4 = 255,
    // so the result always fits in 8 bits without saturation.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] rnd;
    logic             out_valid_q, out_sof_q, out_eol_q;
    pix_t             out_pixel_q;

    assign rnd = sum_q + SUM_W'(8);

    // Valid/flag pipeline; only these carry reset so a reset flushes in-flight
    // results.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            eol1_q      <= 1'b0;
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            eol2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            v1_q        <= fire;
            sof1_q      <= fire && (row_pos == ROW_W'(2)) && (col_pos == COL_W'(2));
            eol1_q      <= fire && (col_pos == COL_W'(IMAGE_WIDTH - 1));
            v2_q        <= v1_q;
            sof2_q      <= sof1_q;
            eol2_q      <= eol1_q;
            out_valid_q <= v2_q;
            out_sof_q   <= sof2_q;
            out_eol_q   <= eol2_q;
            if (v2_q) begin
                out_pixel_q <= rnd[SUM_W-1:gaussian_blur_pkg::NORM_SHIFT];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// -----------------------------------------------------------------------------
// tb_gaussian_blur_3x3
//
// Self-checking bench for gaussian_blur_3x3 on an 8x8 image. Each frame is held
// as a 2D image array; every accepted pixel that completes a window enqueues
// the expected output (direct 3x3 convolution of the image, flags, and the
// cycle it is due). A negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_gaussian_blur_3x3;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_sof;
    logic       out_valid;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eol;

    always #5 clk = ~clk;

    gaussian_blur_3x3 #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_pixel (in_pixel),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_pixel(out_pixel),
        .out_sof  (out_sof),
        .out_eol  (out_eol)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int pix;
        int sof;
        int eol;
        int due;
    } exp_t;

    exp_t q[$];
    int   img[H][W];
    int   k       = 0;   // raster index of the next accepted pixel
    int   out_cnt = 0;

    // Direct 3x3 Gaussian at centre (r,c): weight = (2-|dr|)*(2-|dc|).
    function automatic int model_at(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[r + dr][c + dc];
        return (s + 8) / 16;
    endfunction

    function automatic void fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endfunction

    function automatic void fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            out_cnt++;
            if (q.size() == 0) begin
                check("out_valid_unexpected", int'(out_valid), 0);
            end else begin
                e = q.pop_front();
                check("out_pixel", int'(out_pixel), e.pix);
                check("out_sof",   int'(out_sof),   e.sof);
                check("out_eol",   int'(out_eol),   e.eol);
                check("latency",   cyc,             e.due);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            check("out_valid_when_due", int'(out_valid), 1);
            e = q.pop_front();
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic drive_pix(input bit sof);
        int   r, c;
        exp_t e;
        @(negedge clk);
        if (sof) k = 0;
        r        = k / W;
        c        = k % W;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = 8'(img[r][c]);
        if (r >= 2 && c >= 2) begin
            e.pix = model_at(r - 1, c - 1);
            e.sof = (r == 2 && c == 2) ? 1 : 0;
            e.eol = (c == W - 1) ? 1 : 0;
            e.due = cyc + 3;
            q.push_back(e);
        end
        k = (k + 1) % N;
    endtask

    // Idle cycles; with noise, in_sof toggles without in_valid (must be ignored).
    task automatic idle(input int n, input bit noise);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_pixel = 8'($urandom);
        end
    endtask

    task automatic send(input int n, input int gap_pct, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 2)), 1'b1);
            drive_pix(sof_first && i == 0);
        end
    endtask

    task automatic drain(input string tag, input int exp_cnt);
        int n = 0;
        idle(1, 1'b0);
        while (q.size() > 0 && n < 20) begin
            idle(1, 1'b0);
            n++;
        end
        idle(3, 1'b0);
        check({tag, "_drained"}, q.size(), 0);
        check({tag, "_count"},   out_cnt,  exp_cnt);
        out_cnt = 0;
        q.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_sof",   int'(out_sof),   0);
        check("rst_out_eol",   int'(out_eol),   0);
        rst = 1'b0;
        out_cnt = 0;

        // Constant 100, back to back, with sof.
        fill_const(100);
        send(N, 0, 1'b1);
        drain("const100", 36);

        // All 255, self-timed frame boundary (no sof).
        fill_const(255);
        send(N, 0, 1'b0);
        drain("const255", 36);

        // Impulse at (3,3).
        fill_const(0);
        img[3][3] = 255;
        send(N, 0, 1'b1);
        drain("impulse", 36);

        // Horizontal ramp with ~30% gaps.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = c * 10;
        send(N, 30, 1'b0);
        drain("ramp", 36);

        // Reset after 20 pixels; a pixel presented with rst is dropped.
        fill_rand();
        send(20, 0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pixel = 8'($urandom);
        q.delete();
        k = 0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            check("rst_quiet", int'(out_valid), 0);
            @(negedge clk);
        end
        out_cnt = 0;
        fill_const(50);
        send(N, 0, 1'b0);
        drain("after_rst", 36);

        // sof at pixel 13 of a frame.
        fill_rand();
        send(13, 0, 1'b0);
        fill_const(80);
        send(N, 0, 1'b1);
        drain("sof_resync", 36);

        // Resync while partial-frame results are in flight.
        fill_rand();
        send(21, 20, 1'b0);
        fill_rand();
        send(N, 20, 1'b1);
        drain("resync_inflight", 39);

        // Two random frames back to back with gaps, no sof.
        fill_rand();
        send(N, 10, 1'b0);
        fill_rand();
        send(N, 10, 1'b0);
        drain("random2", 72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
